// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
// Performs one data-memory transaction for loads/stores over a req/ack
// handshake, passes every other instruction straight through, and presents
// registered write-back and branch-redirect outputs.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that sees no
// ack within TIMEOUT cycles (pulses bus_err and retires without write).
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  output logic        exe_ready,
  input  logic [31:0] exe_out,
  input  logic        z_flag,
  input  logic        is_branch,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        needs_wb,
  input  logic [3:0]  rd,
  input  logic [31:0] st_data,
  input  logic [31:0] pc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] pc_out,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

  // Reject out-of-range timeout values at elaboration
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT must be in 1..255");
  end

  state_t      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wb_valid_q;
  logic        wb_en_q;
  logic [3:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [31:0] pc_out_q;
  logic        br_taken_q;
  logic [31:0] br_target_q;
  // Pending memory instruction fields needed at retire
  logic [3:0]  rd_q;
  logic        needs_wb_q;
  logic        is_store_q;
  logic [31:0] pc_q;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
  logic       bus_err_q;
`endif

  // Stage FSM with all registered outputs; pulses default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      pc_out_q    <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      rd_q        <= '0;
      needs_wb_q  <= 1'b0;
      is_store_q  <= 1'b0;
      pc_q        <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (exe_valid) begin
            if (is_load || is_store) begin
              // Launch the memory access; load+store is treated as store
              state_q    <= MEM;
              req_q      <= 1'b1;
              we_q       <= is_store;
              addr_q     <= exe_out;
              wdata_q    <= st_data;
              rd_q       <= rd;
              needs_wb_q <= needs_wb;
              is_store_q <= is_store;
              pc_q       <= pc_in;
`ifdef MEM_TIMEOUT_EN
              cnt_q      <= '0;
`endif
            end else begin
              wb_valid_q  <= 1'b1;
              wb_en_q     <= needs_wb;
              wb_rd_q     <= rd;
              wb_data_q   <= exe_out;
              pc_out_q    <= pc_in;
              br_taken_q  <= is_branch & z_flag;
              br_target_q <= exe_out;
            end
          end
        end
        MEM: begin
          if (dmem_ack) begin
            // Access complete: retire, loads capture read data
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_en_q    <= needs_wb_q & ~is_store_q;
            wb_rd_q    <= rd_q;
            pc_out_q   <= pc_q;
            if (!is_store_q) begin
              wb_data_q <= dmem_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CNT_LIMIT) begin
            // No ack within the limit: abort and retire without write
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            pc_out_q   <= pc_q;
            bus_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
      endcase
    end
  end

  assign exe_ready  = (state_q == IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign pc_out     = pc_out_q;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err    = bus_err_q;
`else
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized traffic checked
// against a transaction-level model (ack latency chosen per access).
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 15;
`endif

  typedef struct {
    logic [31:0] exe_out;
    logic        z;
    logic        br;
    logic        ld;
    logic        st;
    logic        nwb;
    logic [3:0]  rd;
    logic [31:0] st_data;
    logic [31:0] pc;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid;
  logic        exe_ready;
  logic [31:0] exe_out;
  logic        z_flag;
  logic        is_branch;
  logic        is_load;
  logic        is_store;
  logic        needs_wb;
  logic [3:0]  rd;
  logic [31:0] st_data;
  logic [31:0] pc_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pc_out;
  logic        br_taken;
  logic [31:0] br_target;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  // Model state
  bit          busy;
  int          mem_cyc;
  int          ack_at;
  ins_t        pend;
  bit          e_wbv, e_wben, e_br, e_berr, chk_data, chk_id;
  logic [3:0]  e_rd;
  logic [31:0] e_data, e_pc, e_tgt;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_out(exe_out),
    .z_flag(z_flag), .is_branch(is_branch), .is_load(is_load),
    .is_store(is_store), .needs_wb(needs_wb), .rd(rd), .st_data(st_data),
    .pc_in(pc_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .pc_out(pc_out), .br_taken(br_taken),
    .br_target(br_target), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] eo, input logic br, input logic z,
                              input logic ld, input logic st, input logic nwb,
                              input logic [3:0] r, input logic [31:0] sd,
                              input logic [31:0] pc);
    ins_t t;
    t.exe_out = eo; t.br = br; t.z = z; t.ld = ld; t.st = st; t.nwb = nwb;
    t.rd = r; t.st_data = sd; t.pc = pc;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    int k;
    k = $urandom_range(0, 4);
    return mk($urandom, (k == 1) || ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              (k == 2) || (k == 4), (k == 3) || (k == 4), 1'($urandom_range(0, 1)),
              4'($urandom), $urandom, $urandom);
  endfunction

  // Compare every output against the model for the current cycle
  task automatic check_all();
    check("exe_ready", 32'(exe_ready), 32'(!busy));
    check("dmem_req", 32'(dmem_req), 32'(busy));
    check("wb_valid", 32'(wb_valid), 32'(e_wbv));
    check("br_taken", 32'(br_taken), 32'(e_br));
    check("bus_err", 32'(bus_err), 32'(e_berr));
    if (busy) begin
      check("dmem_we", 32'(dmem_we), 32'(pend.st));
      check("dmem_addr", dmem_addr, pend.exe_out);
      check("dmem_wdata", dmem_wdata, pend.st_data);
    end
    if (e_br) check("br_target", br_target, e_tgt);
    if (e_wbv) check("wb_en", 32'(wb_en), 32'(e_wben));
    if (chk_id) begin
      check("wb_rd", 32'(wb_rd), 32'(e_rd));
      check("pc_out", pc_out, e_pc);
    end
    if (chk_data) check("wb_data", wb_data, e_data);
  endtask

  // Drive one cycle of inputs, advance the model, then check at the negedge
  task automatic cycle(input logic v, input ins_t ins, input int lat,
                       input logic [31:0] rdata, input logic noise);
    bit ack;
    ack = busy && (mem_cyc == ack_at);
    exe_valid  = v;
    exe_out    = ins.exe_out;
    z_flag     = ins.z;
    is_branch  = ins.br;
    is_load    = ins.ld;
    is_store   = ins.st;
    needs_wb   = ins.nwb;
    rd         = ins.rd;
    st_data    = ins.st_data;
    pc_in      = ins.pc;
    dmem_ack   = ack || (noise && !busy);
    dmem_rdata = rdata;
    e_wbv = 0; e_br = 0; e_berr = 0; chk_data = 0; chk_id = 0;
    if (busy) begin
      if (ack) begin
        busy = 0; e_wbv = 1; e_wben = pend.nwb && !pend.st;
        e_rd = pend.rd; e_pc = pend.pc; chk_id = 1;
        if (!pend.st) begin e_data = rdata; chk_data = 1; end
      end
`ifdef MEM_TIMEOUT_EN
      else if (mem_cyc == TMO) begin
        busy = 0; e_wbv = 1; e_wben = 0; e_berr = 1;
      end
`endif
      else mem_cyc++;
    end else if (v) begin
      if (ins.ld || ins.st) begin
        busy = 1; pend = ins; mem_cyc = 1; ack_at = lat + 1;
      end else begin
        e_wbv = 1; e_wben = ins.nwb; e_rd = ins.rd; e_pc = ins.pc;
        e_data = ins.exe_out; chk_id = 1; chk_data = 1;
        e_br = ins.br && ins.z; e_tgt = ins.exe_out;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    ins_t t;
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle(1'b0, t, 0, $urandom, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(exe_ready), 32'd1);
    check({tag, "_req"}, 32'(dmem_req), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_br"}, 32'(br_taken), 32'd0);
    check({tag, "_berr"}, 32'(bus_err), 32'd0);
    check({tag, "_wben"}, 32'(wb_en), 32'd0);
    check({tag, "_data"}, wb_data, 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_pc"}, pc_out, 32'd0);
  endtask

  // Async reset applied mid-cycle, checked before the next clock edge
  task automatic do_reset();
    exe_valid = 0; dmem_ack = 0;
    rst = 1;
    #1;
    check_zero("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    busy = 0; e_wbv = 0; e_br = 0; e_berr = 0; chk_data = 0; chk_id = 0;
  endtask

  initial begin
    ins_t t;
    rst = 1; exe_valid = 0; exe_out = 0; z_flag = 0; is_branch = 0;
    is_load = 0; is_store = 0; needs_wb = 0; rd = 0; st_data = 0;
    pc_in = 0; dmem_rdata = 0; dmem_ack = 0;
    busy = 0; mem_cyc = 0; ack_at = 0;
    e_wbv = 0; e_wben = 0; e_br = 0; e_berr = 0; chk_data = 0; chk_id = 0;
    e_rd = 0; e_data = 0; e_pc = 0; e_tgt = 0;
    @(negedge clk);
    check_zero("init");
    rst = 0;

    // ALU passthrough, back-to-back
    cycle(1, mk(32'h0000_1234, 0, 0, 0, 0, 1, 4'd5, 0, 32'h10), 0, 0, 0);
    cycle(1, mk(32'h0000_5678, 0, 0, 0, 0, 1, 4'd6, 0, 32'h14), 0, 0, 0);
    idle(1);

    // Load with ack in the third request cycle
    cycle(1, mk(32'h100, 0, 0, 1, 0, 1, 4'd7, 0, 32'h18), 2, 0, 0);
    for (int i = 0; i < 20 && busy; i++)
      cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 32'hDEAD_BEEF, 0);
    check("load_data", wb_data, 32'hDEAD_BEEF);

    // Store, zero-wait ack
    cycle(1, mk(32'h200, 0, 0, 0, 1, 1, 4'd2, 32'hA5A5_A5A5, 32'h1C), 0, 0, 0);
    idle(2);

    // Branch taken then not taken
    cycle(1, mk(32'h40, 1, 1, 0, 0, 0, 4'd0, 0, 32'h20), 0, 0, 0);
    cycle(1, mk(32'h40, 1, 0, 0, 0, 0, 4'd0, 0, 32'h24), 0, 0, 0);
    idle(1);

    // Reset in the middle of a load, then a stray ack
    cycle(1, mk(32'h300, 0, 0, 1, 0, 1, 4'd3, 0, 32'h28), 10, 0, 0);
    idle(1);
    do_reset();
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, t, 0, $urandom, 1);
    idle(1);

`ifdef MEM_TIMEOUT_EN
    // Access that never completes
    cycle(1, mk(32'h400, 0, 0, 1, 0, 1, 4'd9, 0, 32'h2C), 1000, 0, 0);
    idle(TMO + 1);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      t = rand_ins();
      cycle(1'($urandom_range(0, 1)), t, $urandom_range(0, 5), $urandom,
            1'($urandom_range(0, 3) == 0));
    end

    exe_valid = 0; dmem_ack = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
